// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizing for the shift-add multiplier.
// State encoding matches the controller's IDLE/LOAD/MULT/DONE.
package mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_LOADED = 2'd1,
    R_RUN    = 2'd2,
    R_DONE   = 2'd3
  } mult_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// mult_shift_add: operand, accumulator and step-count registers.
// One partial product is folded into the accumulator per step.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_load,
  input  logic                 i_init,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_acc_next,
  output logic                 o_last,
  output logic                 o_zero_next
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_addend;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign o_acc_next  = r_acc + w_addend;
  assign o_last      = (r_count == CW'(WIDTH - 1));
  assign o_zero_next = ((r_mplier >> 1) == '0);

  // Operand capture, accumulator init and one shift-add per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      if (i_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, i_a};
        r_mplier <= i_b;
      end
      if (i_init) begin
        r_acc   <= '0;
        r_count <= '0;
      end
      if (i_step) begin
        r_acc    <= o_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mult_engine.sv
// mult_engine: load/multiply handshake FSM around mult_shift_add.
// Define MULT_EARLY_EXIT_EN to stop once the multiplier runs out of ones.
module mult_engine
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_data,
  input  logic                 mult_active,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 load_done,
  output logic                 mult_done,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   product
);

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mult_state_e        r_state;
  mult_state_e        w_next;
  logic [2*WIDTH-1:0] r_product;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_last;
  logic               w_zero_next;
  logic               w_exit;
  logic               w_load;
  logic               w_init;
  logic               w_step;

  assign w_exit = w_last || (EARLY && w_zero_next);

  mult_shift_add #(.WIDTH(WIDTH)) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (clr),
    .i_load      (w_load),
    .i_init      (w_init),
    .i_step      (w_step),
    .i_a         (a_in),
    .i_b         (b_in),
    .o_acc_next  (w_acc_next),
    .o_last      (w_last),
    .o_zero_next (w_zero_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= w_next;
  end

  // Next state and datapath enables.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_init = 1'b0;
    w_step = 1'b0;
    if (clr) begin
      w_next = R_IDLE;
    end else begin
      unique case (r_state)
        R_IDLE, R_DONE: begin
          if (load_data) begin
            w_load = 1'b1;
            w_next = R_LOADED;
          end
        end
        R_LOADED: begin
          if (mult_active) begin
            w_init = 1'b1;
            w_next = R_RUN;
          end else if (load_data) begin
            w_load = 1'b1;
          end
        end
        R_RUN: begin
          if (mult_active) begin
            w_step = 1'b1;
            if (w_exit) w_next = R_DONE;
          end else begin
            w_next = R_IDLE;
          end
        end
        default: w_next = R_IDLE;
      endcase
    end
  end

  // Result register, written only by a completing step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_product <= '0;
    else if (clr)              r_product <= '0;
    else if (w_step && w_exit) r_product <= w_acc_next;
  end

  assign load_done = (r_state == R_LOADED);
  assign mult_done = (r_state == R_DONE);
  assign busy      = (r_state == R_RUN);
  assign product   = r_product;

endmodule

// File: tb/tb_mult_engine.sv
// tb_mult_engine: randomized and directed checks of mult_engine
// against a plain-arithmetic product and latency model.
module tb_mult_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        load_data = 1'b0;
  logic        mult_active = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        load_done;
  logic        mult_done;
  logic        busy;
  logic [15:0] product;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] last_prod = '0;

  mult_engine #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .load_data   (load_data),
    .mult_active (mult_active),
    .a_in        (a_in),
    .b_in        (b_in),
    .load_done   (load_done),
    .mult_done   (mult_done),
    .busy        (busy),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges from the first sampled mult_active to mult_done.
  function automatic int exp_lat(input logic [7:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if (b[i]) h = i;
    return (h < 0) ? 2 : h + 2;
`else
    return 9;
`endif
  endfunction

  task automatic do_load(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a_in = a;
    b_in = b;
    load_data = 1'b1;
    mult_active = 1'b0;
    @(posedge clk);
    #1;
    chk("load_done", load_done, 1);
    chk("done_low_after_load", mult_done, 0);
    chk("prod_kept_on_load", product, last_prod);
  endtask

  task automatic run_mult(input logic [7:0] a, input logic [7:0] b);
    int n;
    bit done;
    do_load(a, b);
    @(negedge clk);
    load_data = 1'b0;
    mult_active = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (mult_done) done = 1;
      else chk("prod_hold_run", product, last_prod);
      if (n == 1 && !done) begin
        chk("busy_run", busy, 1);
        chk("load_done_drop", load_done, 0);
      end
    end
    chk("latency", n, exp_lat(b));
    last_prod = 16'(a) * 16'(b);
    chk("product", product, last_prod);
    @(negedge clk);
    mult_active = 1'b0;
    @(posedge clk);
    #1;
    chk("done_hold", mult_done, 1);
  endtask

  task automatic start_partial(input logic [7:0] a, input logic [7:0] b);
    do_load(a, b);
    @(negedge clk);
    load_data = 1'b0;
    mult_active = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    #2;
    chk("rst_load_done", load_done, 0);
    chk("rst_mult_done", mult_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mult(8'd13, 8'd11);

    // Abort after three steps of 7x9.
    start_partial(8'd7, 8'd9);
    @(negedge clk);
    mult_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", mult_done, 0);
      chk("abort_prod", product, 143);
    end

    run_mult(8'd255, 8'd255);
    run_mult(8'd0, 8'd200);
    run_mult(8'd13, 8'd11);
    run_mult(8'd5, 8'd6);

    // Recapture while loaded: the second operands must win.
    do_load(8'd1, 8'd2);
    run_mult(8'd9, 8'd10);

    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (k % 6 == 0) rb = 8'($urandom_range(0, 3));
      run_mult(ra, rb);
    end

    // Asynchronous reset mid-run.
    start_partial(8'd7, 8'd9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_load_done", load_done, 0);
    chk("arst_mult_done", mult_done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_product", product, 0);
    last_prod = '0;
    mult_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Synchronous clear mid-run.
    run_mult(8'd13, 8'd11);
    start_partial(8'd7, 8'd9);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("clr_not_async", product, 143);
    @(posedge clk);
    #1;
    chk("clr_load_done", load_done, 0);
    chk("clr_mult_done", mult_done, 0);
    chk("clr_busy", busy, 0);
    chk("clr_product", product, 0);
    @(negedge clk);
    clr = 1'b0;
    mult_active = 1'b0;
    last_prod = '0;
    run_mult(8'd3, 8'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_engine.md
# mult_engine

Sequential shift-add multiplier datapath that answers the multiply control unit's load/multiply handshake. The control unit drives `load_data` and `mult_active`. This block captures operands, iterates one partial product per cycle, and returns `load_done` and `mult_done`. The registered product feeds the display/scroll logic.

## Interface
- `WIDTH`, 8, operand width in bits; product is 2*WIDTH.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear, same meaning as the control unit's `clr`.
- `load_data` in 1: controller is in LOAD.
- `mult_active` in 1: controller is in MULT.
- `a_in` in WIDTH: multiplicand, already synchronized.
- `b_in` in WIDTH: multiplier, already synchronized.
- `load_done` out 1: operands captured; level signal.
- `mult_done` out 1: product valid; level signal.
- `busy` out 1: high in R_RUN.
- `product` out 2*WIDTH: last completed result, registered.

## Operation
- FSM has four states: R_IDLE, R_LOADED, R_RUN, R_DONE.
- Outputs decode from state:
  - `load_done` = R_LOADED.
  - `mult_done` = R_DONE.
  - `busy` = R_RUN.
- R_IDLE and R_DONE, `load_data`=1: capture `a_in` into `mcand` (2*WIDTH, zero-extended) and `b_in` into `mplier`; go to R_LOADED.
- R_LOADED:
  - `mult_active`=1: clear `acc` and `count`; go to R_RUN.
  - `load_data`=1 with `mult_active`=0: recapture operands, stay in R_LOADED.
- R_RUN, per cycle with `mult_active`=1:
  - if `mplier[0]`, `acc` += `mcand`;
  - `mcand` <<= 1; `mplier` >>= 1; `count`++.
- R_RUN exit: after the step with `count`==WIDTH-1, register `product` = final `acc` and go to R_DONE.
- Arithmetic: `acc` is 2*WIDTH wide, unsigned, and cannot overflow. `count` is clog2(WIDTH+1) bits.
- R_RUN abort: `mult_active`=0 → R_IDLE. `product` is unchanged and `mult_done` is never raised.
- R_DONE: hold `product` and `mult_done` until the next `load_data`.
- `clr`=1 (synchronous, highest priority after reset): go to R_IDLE and zero `product`, `acc`, `count` and the operands.
- `load_data` and `mult_active` both high (illegal from the controller): `mult_active` wins in R_LOADED and R_RUN; `load_data` wins in R_IDLE and R_DONE.

## Timing
- Reset values: state R_IDLE; `load_done`=0, `mult_done`=0, `busy`=0, `product`=0.
- Reset mid-operation aborts immediately and asynchronously.
- Load handshake: `load_data` sampled at edge k → `load_done`=1 after edge k. The controller enters MULT at edge k+1.
- Multiply handshake:
  - `mult_active` sampled at edge t → R_RUN;
  - steps execute at edges t+1 … t+WIDTH;
  - `product` and `mult_done` are valid after edge t+WIDTH.
- Latency is WIDTH+1 edges from the first sampled `mult_active`. No combinational path from inputs to outputs.
- `load_done` drops in the cycle after `mult_active` is sampled. The controller no longer looks at it by then.
- Back-to-back: from R_DONE, `load_data` at edge j → R_LOADED and `mult_done`=0 after edge j. `product` keeps the old value until the new multiply completes.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - R_RUN also exits to R_DONE after any step that leaves `mplier`==0;
  - `mplier`==0 at entry to R_RUN exits after one step with `product`=0;
  - latency is (index of the highest set bit of `b_in`)+2 edges, minimum 2.
- Undefined: always exactly WIDTH steps, giving fixed latency.
- The result value is identical in both builds.

## Structure
- Shared package `mult_pkg` holds:
  - the FSM state typedef (2 bits, same encoding as the controller's IDLE/LOAD/MULT/DONE);
  - default `WIDTH`;
  - `PROD_W` = 2*WIDTH.
- One sub-module, `mult_shift_add`: registered `mcand`/`mplier`/`acc`/`count` with step, init and clear enables. It owns the arithmetic.
- The top level holds the FSM and output decode.

## Test plan (WIDTH=8)
- 13×11:
  - `load_done` one edge after `load_data`;
  - `mult_done` exactly 9 edges after the first sampled `mult_active`;
  - `product`=143.
- 255×255 → `product`=65025 (0xFE01), with no overflow in the high byte.
- 0×200 → `product`=0.
  - `MULT_EARLY_EXIT_EN` build: `mult_done` after 2 edges.
  - Default build: after 9 edges.
- Drop `mult_active` after 3 steps of 7×9 → R_IDLE; `mult_done` never rises; `product` keeps its prior value (143).
- Assert `rst_n`=0 mid-run, then `clr` mid-run → all outputs 0 immediately (reset) or at the next edge (`clr`).
- From R_DONE with `product`=143, reload 5×6 → `mult_done` falls after the `load_data` edge; `product`=30 after 9 edges.
